// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of the SPI flash byte reader.
// Grants are held for a burst; after MAX_BURST bytes a waiting port forces a handoff.
module flash_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int MAX_BURST = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic [7:0]        req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic [7:0]        req1_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [16:0] BURST_LIM = 17'(MAX_BURST);

  state_t            state, state_next;
  logic              last, last_next;
  logic              inflight, inflight_next;
  logic [ADDR_W-1:0] addr_lat, addr_lat_next;
  logic [15:0]       burst_cnt, burst_next;

  logic              own_valid, other_valid;
  logic [ADDR_W-1:0] own_addr;
  logic [16:0]       burst_inc;
  logic              limit_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      inflight  <= 1'b0;
      addr_lat  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      inflight  <= inflight_next;
      addr_lat  <= addr_lat_next;
      burst_cnt <= burst_next;
    end
  end

  always_comb begin
    own_valid   = (state == GNT1) ? req1_valid : req0_valid;
    other_valid = (state == GNT1) ? req0_valid : req1_valid;
    own_addr    = (state == GNT1) ? req1_addr  : req0_addr;
    burst_inc   = {1'b0, burst_cnt} + 17'd1;
    limit_hit   = (burst_inc >= BURST_LIM);

    // Once a transfer is in flight the latched address drives flashmem,
    // even if the owner has dropped valid or moved its address.
    mem_valid = (state != IDLE) && (inflight || own_valid);
    mem_addr  = '0;
    if (state != IDLE)
      mem_addr = inflight ? addr_lat : own_addr;

    req0_ready = (state == GNT0) && mem_ready;
    req1_ready = (state == GNT1) && mem_ready;
    req0_rdata = mem_rdata;
    req1_rdata = mem_rdata;
    grant      = {state == GNT1, state == GNT0};
    busy       = (state != IDLE) && mem_valid;
  end

  always_comb begin
    state_next    = state;
    last_next     = last;
    inflight_next = inflight;
    addr_lat_next = addr_lat;
    burst_next    = burst_cnt;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid)
          state_next = last ? GNT0 : GNT1;
        else if (req0_valid)
          state_next = GNT0;
        else if (req1_valid)
          state_next = GNT1;
        if (req0_valid || req1_valid)
          burst_next = '0;
      end
      default: begin
        if (mem_ready) begin
          inflight_next = 1'b0;
          burst_next    = limit_hit ? BURST_LIM[15:0] : burst_inc[15:0];
          if (limit_hit && other_valid) begin
            state_next = IDLE;
            last_next  = (state == GNT1);
          end
        end else if (!inflight && !own_valid) begin
          state_next = IDLE;
          last_next  = (state == GNT1);
        end else if (!inflight) begin
          inflight_next = 1'b1;
          addr_lat_next = own_addr;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: flashmem answers 5 cycles after valid
// with a byte derived from the address; requesters stream or act per step.
module tb_flash_arbiter;

  localparam int LAT = 5;

  logic        clock;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_rdata, req1_rdata;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [1:0]  grant;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int fcnt = 0;

  logic [1:0] glog[$];
  int         olog[$];
  int         rcyc[$];

  flash_arbiter #(.ADDR_W(24), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Inputs are set at +1 after the edge; flashmem responds at +2; checks follow at +3.
  task automatic settle();
    #1;
    if (reset || !mem_valid) begin
      fcnt = 0;
      mem_ready = 1'b0;
    end else if (fcnt == LAT) begin
      mem_ready = 1'b1;
      mem_rdata = fbyte(mem_addr);
      fcnt = 0;
    end else begin
      mem_ready = 1'b0;
      fcnt++;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  function automatic int count_g(input logic [1:0] v);
    int n;
    n = 0;
    foreach (glog[i]) if (glog[i] === v) n++;
    return n;
  endfunction

  function automatic logic [31:0] order_bits();
    logic [31:0] r;
    r = '0;
    foreach (olog[i]) if (i < 32) r[i] = (olog[i] == 1);
    return r;
  endfunction

  // Streaming requesters: hold valid until ready, then present the next address.
  task automatic serve(input int n0, input logic [23:0] b0, input int n1, input logic [23:0] b1,
                       input int limit);
    int rem0, rem1;
    logic [23:0] a0, a1;
    rem0 = n0; rem1 = n1; a0 = b0; a1 = b1;
    glog.delete(); olog.delete(); rcyc.delete();
    for (int c = 0; c < limit && (rem0 != 0 || rem1 != 0); c++) begin
      req0_valid = (rem0 != 0);
      req0_addr  = a0;
      req1_valid = (rem1 != 0);
      req1_addr  = a1;
      settle();
      glog.push_back(grant);
      if (req0_ready) begin
        check("rdata0", req0_rdata, fbyte(a0));
        check("owner0", grant, 2'b01);
        olog.push_back(0); rcyc.push_back(c);
        rem0--; a0++;
      end
      if (req1_ready) begin
        check("rdata1", req1_rdata, fbyte(a1));
        check("owner1", grant, 2'b10);
        olog.push_back(1); rcyc.push_back(c);
        rem1--; a1++;
      end
      tick();
    end
    check("serve_done", rem0 + rem1, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick();

    // reset state
    settle();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    tick();
    reset = 1'b0;
    idle(1);

    // single requester, 4 bytes
    serve(4, 24'h400000, 0, 24'h0, 100);
    check("t1_cnt", olog.size(), 4);
    check("t1_first_rdy", rcyc[0], 6);
    check("t1_last_rdy", rcyc[3], 24);
    check("t1_g00", count_g(2'b00), 1);
    check("t1_g01", count_g(2'b01), 24);
    settle();
    check("t1_drop_grant", grant, 2'b01);
    check("t1_drop_mv", mem_valid, 0);
    tick();
    settle();
    check("t1_idle", grant, 2'b00);
    tick();

    // reset then simultaneous contention
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0;
    serve(2, 24'h010000, 1, 24'h020000, 100);
    check("t2_order", order_bits(), 32'b100);
    check("t2_first_g", glog[1], 2'b01);
    check("t2_rel", glog[13], 2'b01);
    check("t2_gap", glog[14], 2'b00);
    check("t2_g1", glog[15], 2'b10);
    check("t2_rdy1", rcyc[2], 20);
    idle(3);

    // forced handoff, both streaming
    serve(8, 24'h100000, 8, 24'h200000, 300);
    check("t3_order", order_bits(), 32'hF0F0);
    check("t3_cnt", olog.size(), 16);
    check("t3_h1a", glog[24], 2'b01);
    check("t3_h1b", glog[25], 2'b00);
    check("t3_h1c", glog[26], 2'b10);
    check("t3_h2b", glog[50], 2'b00);
    check("t3_h2c", glog[51], 2'b01);
    check("t3_g00", count_g(2'b00), 4);
    check("t3_last", rcyc[15], 99);
    idle(3);

    // burst limit with no contender
    serve(0, 24'h0, 10, 24'h300000, 200);
    check("t4_order", order_bits(), 32'h3FF);
    check("t4_g10", count_g(2'b10), 60);
    check("t4_g00", count_g(2'b00), 1);
    check("t4_g01", count_g(2'b01), 0);
    check("t4_last", rcyc[9], 60);
    idle(3);

    // abandoned request
    req0_valid = 1'b1; req0_addr = 24'h123456;
    settle();
    check("t5_c0_grant", grant, 0);
    check("t5_c0_mv", mem_valid, 0);
    tick();
    settle();
    check("t5_c1_grant", grant, 2'b01);
    check("t5_c1_mv", mem_valid, 1);
    check("t5_c1_addr", mem_addr, 24'h123456);
    check("t5_c1_busy", busy, 1);
    tick();
    req0_valid = 1'b0; req0_addr = 24'h00ABCD;
    req1_valid = 1'b1; req1_addr = 24'h200000;
    for (int i = 2; i < 6; i++) begin
      settle();
      check("t5_hold_mv", mem_valid, 1);
      check("t5_hold_addr", mem_addr, 24'h123456);
      check("t5_hold_rdy", {req0_ready, req1_ready}, 0);
      check("t5_hold_grant", grant, 2'b01);
      tick();
    end
    settle();
    check("t5_rdy0", req0_ready, 1);
    check("t5_rdy1", req1_ready, 0);
    check("t5_rdata", req0_rdata, fbyte(24'h123456));
    check("t5_rdy_addr", mem_addr, 24'h123456);
    tick();
    settle();
    check("t5_after_grant", grant, 2'b01);
    check("t5_after_mv", mem_valid, 0);
    tick();
    settle();
    check("t5_idle", grant, 2'b00);
    tick();
    req1_valid = 1'b0;
    settle();
    check("t5_g1", grant, 2'b10);
    check("t5_g1_mv", mem_valid, 0);
    tick();
    idle(3);

    // reset mid-transfer; make last=0 first so a stale last would favour port 1
    serve(1, 24'h000010, 0, 24'h0, 50);
    idle(2);
    req1_valid = 1'b1; req1_addr = 24'h0A0A0A;
    settle();
    check("t6_c0_grant", grant, 0);
    tick();
    settle();
    check("t6_c1_grant", grant, 2'b10);
    check("t6_c1_mv", mem_valid, 1);
    tick();
    reset = 1'b1;
    settle();
    check("t6_inflight_mv", mem_valid, 1);
    check("t6_inflight_addr", mem_addr, 24'h0A0A0A);
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 24'h000020;
    settle();
    check("t6_rst_mv", mem_valid, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", mem_addr, 0);
    tick();
    settle();
    check("t6_first_grant", grant, 2'b01);
    tick();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
